// File: rtl/if_pkg.sv
// Shared types and constants for the IF->ID decoupling queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013; // ADDI x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Entry array for the IF->ID queue: one synchronous write port, one async read port.
// Latency: write visible on read port after the writing edge; read is combinational.
// Backpressure: none; the owner decides when to write.
module ifq_storage import if_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ifq_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ifq_entry_t               rdata
);

  ifq_entry_t mem_q [DEPTH];

  // Entry contents carry no reset; validity is tracked by the queue count.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: stores {pc, instr}, presents the head as registered id_* outputs.
// Latency: 1 cycle into an empty queue; otherwise after all older entries dequeue.
// Backpressure: if_ready = (count < DEPTH), independent of id_ready; flush wins over all.
// Optional: define IFQ_MISALIGN_CHECK_EN to add id_misalign (head pc[1:0] != 0 -> NOP).
module if_id_queue #(
  parameter int          XLEN      = if_pkg::XLEN,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [31:0]                if_instr,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_pc4,
  output logic [31:0]                id_instr,
`ifdef IFQ_MISALIGN_CHECK_EN
  output logic                       id_misalign,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  import if_pkg::*;

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
  logic [31:0]     id_instr_q, id_instr_d;
`ifdef IFQ_MISALIGN_CHECK_EN
  logic            id_misalign_q, id_misalign_d;
`endif

  logic       enq, deq, head_is_new;
  ifq_entry_t wr_entry, rd_entry, head;

  assign if_ready = (count_q < DEPTH_C);

  // Handshakes, pointer and count update; flush discards everything in flight.
  always_comb begin
    enq            = if_valid && if_ready;
    deq            = id_valid_q && id_ready;
    wr_entry.pc    = if_pc;
    wr_entry.instr = if_instr;
    rptr_d         = rptr_q;
    wptr_d         = wptr_q;
    count_d        = count_q;
    // The new head is the incoming entry when the queue drains to empty this cycle.
    head_is_new    = enq && (count_q == CW'(deq));
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + PW'(1);
      if (deq) rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  ifq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (enq && !flush),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .raddr (rptr_d),
    .rdata (rd_entry)
  );

  // Next registered head: bypass the write data when the entry lands in an empty slot.
  always_comb begin
    head       = head_is_new ? wr_entry : rd_entry;
    id_valid_d = 1'b0;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_instr_d = NOP_INSTR;
`ifdef IFQ_MISALIGN_CHECK_EN
    id_misalign_d = 1'b0;
`endif
    if (count_d != '0) begin
      id_valid_d = 1'b1;
      id_pc_d    = head.pc;
      id_pc4_d   = head.pc + XLEN'(4);
      id_instr_d = head.instr;
`ifdef IFQ_MISALIGN_CHECK_EN
      if (head.pc[1:0] != 2'b00) begin
        id_misalign_d = 1'b1;
        id_instr_d    = NOP_INSTR;
      end
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pc4_q   <= XLEN'(4);
      id_instr_q <= NOP_INSTR;
`ifdef IFQ_MISALIGN_CHECK_EN
      id_misalign_q <= 1'b0;
`endif
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
`ifdef IFQ_MISALIGN_CHECK_EN
      id_misalign_q <= id_misalign_d;
`endif
    end
  end

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_instr  = id_instr_q;
  assign occupancy = count_q;
`ifdef IFQ_MISALIGN_CHECK_EN
  assign id_misalign = id_misalign_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus a randomized run against a queue model.
// Latency: model expects head visible one edge after it becomes head.
// Backpressure: IF holds its entry until accepted; ID stalls at random.
module tb_if_id_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready, flush, id_ready, id_valid;
  logic [31:0] if_pc, if_instr, id_pc, id_pc4, id_instr;
  logic [1:0]  occupancy;
`ifdef IFQ_MISALIGN_CHECK_EN
  logic        id_misalign;
`endif

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [31:0] last_pc;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk       (clk),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .flush     (flush),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_pc4    (id_pc4),
    .id_instr  (id_instr),
`ifdef IFQ_MISALIGN_CHECK_EN
    .id_misalign (id_misalign),
`endif
    .occupancy (occupancy)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  // Expected id_instr from the model: head instruction, NOP when empty or misaligned.
  function automatic logic [31:0] exp_instr();
    if (mq.size() == 0) return NOP;
`ifdef IFQ_MISALIGN_CHECK_EN
    if (mq[0].pc[1:0] != 2'b00) return NOP;
`endif
    return mq[0].instr;
  endfunction

  // Drive one cycle, advance the model across the edge, return whether IF was accepted.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, output logic acc);
    logic deq;
    if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
    acc = v && (mq.size() < DEPTH) && !fl;
    deq = rdy && (mq.size() > 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc, instr: ins});
    end
    if (mq.size() > 0) last_pc = mq[0].pc;
    #1;
    if_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_valid = 0; if_pc = 0; if_instr = 0; flush = 0; id_ready = 0;
    mq.delete(); last_pc = 32'h0;
    #12 reset = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", id_instr, NOP); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b want 1", if_ready); end
    checks++; if (id_pc4 !== 32'h4 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h/%h want 0/4", id_pc, id_pc4); end
  endtask

  task automatic test_fill_stall();
    logic acc;
    tick(1'b1, 32'h0, mk_instr(32'h0), 1'b0, 1'b0, acc);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== mk_instr(32'h0)) begin
      errors++; $display("FAIL first_latency got v=%b pc=%h i=%h want 1/0/%h", id_valid, id_pc, id_instr, mk_instr(32'h0)); end
    tick(1'b1, 32'h4, mk_instr(32'h4), 1'b0, 1'b0, acc);
    tick(1'b1, 32'h8, mk_instr(32'h8), 1'b0, 1'b0, acc);
    checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_push_ignored got acc=%b want 0", acc); end
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL full_occ got %0d want 2", occupancy); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL full_if_ready got %b want 0", if_ready); end
    checks++; if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin errors++; $display("FAIL full_head got %h/%h want 0/4", id_pc, id_pc4); end
  endtask

  task automatic test_drain();
    logic [31:0] exp_seq [6];
    logic [31:0] p;
    logic        acc;
    int          k = 0;
    exp_seq = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    p = 32'h8;
    for (int c = 0; c < 6; c++) begin
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_seq[k] || id_instr !== mk_instr(exp_seq[k])) begin
        errors++; $display("FAIL drain_order[%0d] got v=%b pc=%h i=%h want pc=%h", k, id_valid, id_pc, id_instr, exp_seq[k]); end
      k++;
      tick(1'b1, p, mk_instr(p), 1'b1, 1'b0, acc);
      if (acc) p = p + 32'h4;
    end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL steady_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_flush();
    logic acc;
    tick(1'b1, 32'h200, mk_instr(32'h200), 1'b0, 1'b0, acc);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL preflush_occ got %0d want 2", occupancy); end
    tick(1'b1, 32'h300, mk_instr(32'h300), 1'b1, 1'b1, acc);
    checks++; if (occupancy !== 2'd0 || id_valid !== 1'b0 || id_instr !== NOP) begin
      errors++; $display("FAIL flush_state got occ=%0d v=%b i=%h want 0/0/%h", occupancy, id_valid, id_instr, NOP); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_if_ready got %b want 1", if_ready); end
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++; $display("FAIL flushed_push_leak[%0d] got v=%b occ=%0d want 0/0", c, id_valid, occupancy); end
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    tick(1'b1, 32'h400, mk_instr(32'h400), 1'b0, 1'b0, acc);
    tick(1'b1, 32'h404, mk_instr(32'h404), 1'b0, 1'b0, acc);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || occupancy !== 2'd0 || id_instr !== NOP) begin
      errors++; $display("FAIL async_reset got v=%b occ=%0d i=%h want 0/0/%h", id_valid, occupancy, id_instr, NOP); end
    checks++; if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin
      errors++; $display("FAIL async_reset_pc got %h/%h want 0/4", id_pc, id_pc4); end
    @(negedge clk);
    reset = 1'b0;
    mq.delete(); last_pc = 32'h0;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL post_reset_if_ready got %b want 1", if_ready); end
  endtask

  task automatic test_random();
    logic [31:0] p, ins;
    logic        have, v, rdy, fl, acc;
    int          r;
    have = 1'b0; p = 0; ins = 0;
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        r = $urandom_range(0, 15);
        if (r == 0)      p = 32'hFFFF_FFFC;
        else if (r == 1) p = $urandom;
        else             p = $urandom & 32'hFFFF_FFFC;
        ins  = $urandom;
        have = 1'b1;
      end
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      tick(v, p, ins, rdy, fl, acc);
      if (acc || (fl && v)) have = 1'b0;
      checks++;
      if (id_valid !== (mq.size() != 0) || occupancy !== 2'(mq.size())
          || if_ready !== (mq.size() < DEPTH) || id_instr !== exp_instr()
          || id_pc !== last_pc || id_pc4 !== last_pc + 32'h4) begin
        errors++;
        $display("FAIL random[%0d] got v=%b occ=%0d rdy=%b pc=%h pc4=%h i=%h want v=%b occ=%0d pc=%h i=%h",
                 c, id_valid, occupancy, if_ready, id_pc, id_pc4, id_instr,
                 mq.size() != 0, mq.size(), last_pc, exp_instr());
      end
`ifdef IFQ_MISALIGN_CHECK_EN
      checks++;
      if (id_misalign !== (mq.size() != 0 && mq[0].pc[1:0] != 2'b00)) begin
        errors++; $display("FAIL random_misalign[%0d] got %b", c, id_misalign);
      end
`endif
    end
  endtask

`ifdef IFQ_MISALIGN_CHECK_EN
  task automatic test_misalign();
    logic acc;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    tick(1'b1, 32'h1002, 32'h00500093, 1'b0, 1'b0, acc);
    checks++; if (id_misalign !== 1'b1 || id_instr !== NOP || id_valid !== 1'b1 || id_pc !== 32'h1002) begin
      errors++; $display("FAIL misalign got m=%b i=%h v=%b pc=%h want 1/%h/1/1002", id_misalign, id_instr, id_valid, id_pc, NOP); end
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    checks++; if (id_misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b want 0", id_misalign); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_stall();
    test_drain();
    test_flush();
    test_async_reset();
    test_random();
`ifdef IFQ_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
